// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a word-addressed instruction memory from RESET_PC,
// hands each word to a consumer over a valid/ready handshake, and honours branch redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired_count
);

    typedef enum logic [2:0] {IDLE, ISSUE, RESP, VALID, HALT, FAULT} state_t;

    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    state_t      state;
    logic [31:0] pc;
    logic        pc_bad;
    logic        handshake;
    logic [15:0] count_next;

    assign mem_addr   = pc;
    assign pc_bad     = (pc[1:0] != 2'b00) || ({1'b0, pc} >= MEM_BYTES);
    assign handshake  = instr_valid && out_ready;
    assign count_next = (retired_count == 16'hFFFF) ? retired_count : retired_count + 16'd1;

    // NOTE: every register here is state, so all assignments are non-blocking; a blocking
    // assignment would let later statements in the same edge see the new value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr         <= 32'h0;
            instr_pc      <= 32'h0;
            instr_valid   <= 1'b0;
            halted        <= 1'b0;
            fault         <= 1'b0;
            retired_count <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= ISSUE;
                end
                ISSUE: begin
                    // A redirect replaces the address before it is checked or issued.
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (pc_bad) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= ISSUE;
                    end else if (mem_rdata == 32'h0) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        instr       <= mem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    if (handshake) retired_count <= count_next;
                    if (redirect_valid) begin
                        pc          <= redirect_pc;
                        instr_valid <= 1'b0;
                        state       <= ISSUE;
                    end else if (handshake) begin
                        pc          <= pc + 32'd4;
                        instr_valid <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                HALT, FAULT: begin
                    if (start) begin
                        pc            <= RESET_PC;
                        retired_count <= 16'h0;
                        halted        <= 1'b0;
                        fault         <= 1'b0;
                        state         <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized programs,
// handshakes and redirects checked against a program-order reference model.
module tb_fetch_sequencer;

    localparam int          MEM_WORDS = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PROG [4]  = '{32'h0070_0113, 32'h0080_0093, 32'h0020_81B3, 32'h0000_0000};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;
    logic        fault;
    logic [15:0] retired_count;

    logic [31:0] mem [MEM_WORDS];

    int passed = 0;
    int total  = 0;

    fetch_sequencer #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .out_ready(out_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
        .fault(fault), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk)
        mem_rdata <= ({2'b00, mem_addr[31:2]} < 32'(MEM_WORDS)) ? mem[mem_addr[6:2]] : 32'h0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; i < limit && instr_valid !== 1'b1; i++) tick();
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && halted !== 1'b1 && fault !== 1'b1; i++) tick();
    endtask

    task automatic load_program();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = (i < 4) ? PROG[i] : 32'h0;
    endtask

    task automatic test_reset();
        load_program();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({instr_valid, halted, fault} !== 3'b000)
            $display("FAIL reset_flags: got valid/halted/fault=%b expected 000", {instr_valid, halted, fault});
        else passed++;
        total++;
        if (mem_addr !== RESET_PC) $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, RESET_PC);
        else passed++;
        total++;
        if (instr !== 32'h0 || instr_pc !== 32'h0)
            $display("FAIL reset_instr: got instr=%h pc=%h expected 0/0", instr, instr_pc);
        else passed++;
        total++;
        if (retired_count !== 16'h0) $display("FAIL reset_count: got %0d expected 0", retired_count);
        else passed++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_program();
        int n    = 0;
        int last = 0;
        out_ready = 1'b1;
        pulse_start();
        total++;
        if (instr_valid !== 1'b0) $display("FAIL latency_edge1: got valid=%b expected 0", instr_valid);
        else passed++;
        tick();
        total++;
        if (instr_valid !== 1'b0) $display("FAIL latency_edge2: got valid=%b expected 0", instr_valid);
        else passed++;
        tick();
        total++;
        if (instr_valid !== 1'b1) $display("FAIL latency_edge3: got valid=%b expected 1", instr_valid);
        else passed++;
        for (int cyc = 0; cyc < 60 && halted !== 1'b1; cyc++) begin
            if (instr_valid === 1'b1) begin
                total++;
                if (n > 2 || instr !== PROG[n] || instr_pc !== 32'(4 * n))
                    $display("FAIL prog_instr%0d: got %h@%h expected %h@%h", n, instr, instr_pc,
                             (n < 4) ? PROG[n] : 32'h0, 32'(4 * n));
                else passed++;
                if (n > 0) begin
                    total++;
                    if (cyc - last != 3) $display("FAIL prog_spacing%0d: got %0d cycles expected 3", n, cyc - last);
                    else passed++;
                end
                last = cyc;
                n++;
            end
            tick();
        end
        total++;
        if (halted !== 1'b1 || fault !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL prog_halt: got halted/fault/valid=%b expected 100", {halted, fault, instr_valid});
        else passed++;
        total++;
        if (retired_count !== 16'd3 || n != 3)
            $display("FAIL prog_count: got count=%0d delivered=%0d expected 3", retired_count, n);
        else passed++;
        total++;
        if (mem_addr !== 32'd12) $display("FAIL prog_halt_addr: got %h expected 0000000c", mem_addr);
        else passed++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        pulse_start();
        wait_valid(10);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (instr_valid !== 1'b1 || instr !== PROG[0] || instr_pc !== 32'h0 || mem_addr !== 32'h0 ||
                retired_count !== 16'h0)
                $display("FAIL stall_hold%0d: got valid=%b %h@%h addr=%h count=%0d expected 1 %h@0 addr=0 count=0",
                         k, instr_valid, instr, instr_pc, mem_addr, retired_count, PROG[0]);
            else passed++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (retired_count !== 16'd1 || instr_valid !== 1'b0 || mem_addr !== 32'd4)
            $display("FAIL stall_release: got count=%0d valid=%b addr=%h expected 1 0 00000004",
                     retired_count, instr_valid, mem_addr);
        else passed++;
        wait_done(30);
        total++;
        if (halted !== 1'b1 || retired_count !== 16'd3)
            $display("FAIL stall_finish: got halted=%b count=%0d expected 1 3", halted, retired_count);
        else passed++;
    endtask

    task automatic test_redirect_resp();
        out_ready = 1'b1;
        pulse_start();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd8;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || mem_addr !== 32'd8)
            $display("FAIL redir_resp_pc: got valid=%b addr=%h expected 0 00000008", instr_valid, mem_addr);
        else passed++;
        wait_valid(10);
        total++;
        if (instr_valid !== 1'b1 || instr !== PROG[2] || instr_pc !== 32'd8)
            $display("FAIL redir_resp_first: got valid=%b %h@%h expected 1 %h@00000008",
                     instr_valid, instr, instr_pc, PROG[2]);
        else passed++;
        wait_done(20);
        total++;
        if (halted !== 1'b1 || retired_count !== 16'd1)
            $display("FAIL redir_resp_finish: got halted=%b count=%0d expected 1 1", halted, retired_count);
        else passed++;
    endtask

    task automatic test_fault_redirect();
        out_ready = 1'b0;
        pulse_start();
        wait_valid(10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0006;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (fault !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 32'h6)
            $display("FAIL fault_issue: got fault=%b valid=%b addr=%h expected 0 0 00000006",
                     fault, instr_valid, mem_addr);
        else passed++;
        tick();
        total++;
        if (fault !== 1'b1 || halted !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL fault_state: got fault/halted/valid=%b expected 100", {fault, halted, instr_valid});
        else passed++;
        out_ready = 1'b1;
        pulse_start();
        total++;
        if (fault !== 1'b0 || retired_count !== 16'h0 || mem_addr !== RESET_PC)
            $display("FAIL fault_restart: got fault=%b count=%0d addr=%h expected 0 0 %h",
                     fault, retired_count, mem_addr, RESET_PC);
        else passed++;
        wait_valid(10);
        total++;
        if (instr_valid !== 1'b1 || instr !== PROG[0] || instr_pc !== 32'h0)
            $display("FAIL fault_resume: got valid=%b %h@%h expected 1 %h@0", instr_valid, instr, instr_pc, PROG[0]);
        else passed++;
        wait_done(30);
    endtask

    task automatic test_full_range();
        int n = 0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom | 32'd1;
        out_ready = 1'b1;
        pulse_start();
        for (int cyc = 0; cyc < 200 && halted !== 1'b1 && fault !== 1'b1; cyc++) begin
            if (instr_valid === 1'b1) begin
                total++;
                if (n >= MEM_WORDS || instr !== mem[n[4:0]] || instr_pc !== 32'(4 * n))
                    $display("FAIL range_instr%0d: got %h@%h expected %h@%h", n, instr, instr_pc,
                             mem[n[4:0]], 32'(4 * n));
                else passed++;
                n++;
            end
            tick();
        end
        total++;
        if (fault !== 1'b1 || halted !== 1'b0 || mem_addr !== 32'd128)
            $display("FAIL range_fault: got fault=%b halted=%b addr=%h expected 1 0 00000080", fault, halted, mem_addr);
        else passed++;
        total++;
        if (retired_count !== 16'd32 || n != 32)
            $display("FAIL range_count: got count=%0d delivered=%0d expected 32", retired_count, n);
        else passed++;
    endtask

    task automatic test_reset_mid();
        load_program();
        out_ready = 1'b1;
        pulse_start();
        wait_valid(10);
        tick();
        out_ready = 1'b0;
        wait_valid(10);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({instr_valid, halted, fault} !== 3'b000 || instr !== 32'h0 || instr_pc !== 32'h0 ||
            mem_addr !== RESET_PC || retired_count !== 16'h0)
            $display("FAIL reset_mid: got valid/halted/fault=%b instr=%h pc=%h addr=%h count=%0d expected all reset values",
                     {instr_valid, halted, fault}, instr, instr_pc, mem_addr, retired_count);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        pulse_start();
        tick();
        total++;
        if (instr_valid !== 1'b0) $display("FAIL reset_first_start_early: got valid=%b expected 0", instr_valid);
        else passed++;
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || retired_count !== 16'h0)
            $display("FAIL reset_first_start: got valid=%b pc=%h count=%0d expected 1 0 0",
                     instr_valid, instr_pc, retired_count);
        else passed++;
        wait_done(30);
    endtask

    // Reference model: the expected stream is program order from the last start or
    // redirect target; the run ends at the first zero word (halt) or illegal address (fault).
    task automatic test_random(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            logic [31:0] exp_pc     = RESET_PC;
            int          exp_cnt    = 0;
            logic        prev_hold  = 1'b0;
            logic [31:0] prev_instr = 32'h0;
            logic [31:0] prev_pc    = 32'h0;
            logic        exp_fault;
            for (int i = 0; i < MEM_WORDS; i++)
                mem[i] = (i != 0 && $urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'd1);
            redirect_valid = 1'b0;
            pulse_start();
            for (int cyc = 0; cyc < 3000 && halted !== 1'b1 && fault !== 1'b1; cyc++) begin
                if (prev_hold) begin
                    total++;
                    if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc)
                        $display("FAIL rnd%0d_hold: got valid=%b %h@%h expected 1 %h@%h",
                                 r, instr_valid, instr, instr_pc, prev_instr, prev_pc);
                    else passed++;
                end
                out_ready      = ($urandom_range(0, 2) != 0);
                redirect_valid = (instr_valid === 1'b1) && ($urandom_range(0, 5) == 0);
                case ($urandom_range(0, 9))
                    0:       redirect_pc = 32'($urandom_range(0, 31)) * 32'd4 + 32'd2;
                    1:       redirect_pc = 32'd128 + 32'($urandom_range(0, 63)) * 32'd4;
                    default: redirect_pc = 32'($urandom_range(0, 31)) * 32'd4;
                endcase
                if (instr_valid === 1'b1 && out_ready) begin
                    total++;
                    if (instr !== mem[exp_pc[6:2]] || instr_pc !== exp_pc)
                        $display("FAIL rnd%0d_instr: got %h@%h expected %h@%h", r, instr, instr_pc,
                                 mem[exp_pc[6:2]], exp_pc);
                    else passed++;
                    exp_pc  = exp_pc + 32'd4;
                    exp_cnt = exp_cnt + 1;
                end
                if (redirect_valid) exp_pc = redirect_pc;
                prev_hold  = (instr_valid === 1'b1) && !out_ready && !redirect_valid;
                prev_instr = instr;
                prev_pc    = instr_pc;
                tick();
            end
            redirect_valid = 1'b0;
            exp_fault = (exp_pc[1:0] != 2'b00) || (exp_pc >= 32'(MEM_WORDS * 4));
            total++;
            if ({halted, fault} !== {!exp_fault, exp_fault} || mem_addr !== exp_pc)
                $display("FAIL rnd%0d_end: got halted/fault=%b addr=%h expected %b addr=%h",
                         r, {halted, fault}, mem_addr, {!exp_fault, exp_fault}, exp_pc);
            else passed++;
            total++;
            if (retired_count !== 16'(exp_cnt))
                $display("FAIL rnd%0d_count: got %0d expected %0d", r, retired_count, exp_cnt);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_stall();
        test_redirect_resp();
        test_fault_redirect();
        test_full_range();
        test_reset_mid();
        test_random(6);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the start address loaded at reset and on restart.
REQ-002 Parameter MEM_WORDS, default 32, is the number of 32-bit words in the attached instruction memory.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins fetching from IDLE, or restarts from HALT/FAULT.
REQ-006 mem_addr  output  32  byte address presented to instruction memory (word index = mem_addr/4).
REQ-007 mem_rdata  input  32  instruction word; memory registers it on the clk edge that samples mem_addr.
REQ-008 instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-009 instr  output  32  fetched instruction word.
REQ-010 instr_pc  output  32  byte address of instr.
REQ-011 out_ready  input  1  consumer accepts instr when high with instr_valid high (handshake).
REQ-012 redirect_valid  input  1  branch/jump redirect request.
REQ-013 redirect_pc  input  32  redirect target byte address.
REQ-014 halted  output  1  high in HALT state.
REQ-015 fault  output  1  high in FAULT state.
REQ-016 retired_count  output  16  number of completed handshakes since reset/restart.

Function
REQ-017 States: IDLE, ISSUE, RESP, VALID, HALT, FAULT; state and all registers update only on rising clk, except reset.
REQ-018 mem_addr shall equal internal pc in every state.
REQ-019 IDLE: start=1 -> ISSUE; otherwise stay.
REQ-020 ISSUE: if pc[1:0]!=0 or pc >= MEM_WORDS*4 -> FAULT; else -> RESP (memory samples pc this edge).
REQ-021 RESP: mem_rdata==0 -> HALT, instr_valid stays 0; else capture instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, -> VALID.
REQ-022 VALID: instr, instr_pc, instr_valid held stable until handshake; on handshake instr_valid<=0, pc<=pc+4, retired_count increments, -> ISSUE.
REQ-023 Sustained throughput is one instruction per 3 cycles with out_ready tied high; first instr_valid is the 3rd edge after start is sampled.
REQ-024 redirect_valid in ISSUE, RESP or VALID: pc<=redirect_pc, in-flight read discarded, instr_valid<=0, -> ISSUE next cycle; ignored in IDLE, HALT, FAULT.
REQ-025 Redirect and handshake in the same VALID cycle: handshake completes (retired_count increments), pc takes redirect_pc, not pc+4.
REQ-026 Misaligned or out-of-range redirect_pc is accepted and faults in the following ISSUE cycle (REQ-020).
REQ-027 pc+4 wraps modulo 2^32; wrap past MEM_WORDS*4 faults per REQ-020.
REQ-028 retired_count saturates at 16'hFFFF.
REQ-029 HALT/FAULT: outputs frozen except instr_valid=0; start=1 -> pc<=RESET_PC, retired_count<=0, -> ISSUE.
REQ-030 start is ignored in ISSUE, RESP, VALID.

Reset
REQ-031 reset low asynchronously forces: state=IDLE, pc=RESET_PC, mem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, fault=0, retired_count=0.
REQ-032 reset asserted mid-operation discards any in-flight fetch; no handshake is recorded for it.
REQ-033 First start honoured on the first rising edge after reset deasserts.

Verification
REQ-034 Memory words 0..3 = 00700113, 00800093, 002081B3, 00000000; start, out_ready=1 -> instr 00700113@0, 00800093@4, 002081B3@8, then halted=1, retired_count=3.
REQ-035 Same program, out_ready=0 for 5 cycles at first VALID -> instr=00700113, instr_pc=0 held stable all 5 cycles, no pc advance.
REQ-036 redirect_valid=1, redirect_pc=8 during first RESP -> no instr@0 delivered; next instr_valid shows 002081B3@8.
REQ-037 redirect_pc=32'h0000_0006 -> fault=1 two cycles later, instr_valid=0; start -> fetch resumes at 0 with retired_count=0.
REQ-038 Word 31 nonzero, all prior nonzero, out_ready=1 -> after instr@124 handshake, pc=128 -> fault=1, retired_count=32.
REQ-039 reset pulsed low while in VALID -> outputs at reset values immediately, state IDLE, no count increment.
